// File: rtl/eth_mdio_pkg.sv
// eth_mdio_pkg: shared MDIO opcodes, PHY register constants and controller states
package eth_mdio_pkg;
  localparam logic [1:0] OP_WR = 2'b01;
  localparam logic [1:0] OP_RD = 2'b10;
  localparam logic [4:0] REG_BMCR = 5'd0;
  localparam logic [4:0] REG_BMSR = 5'd1;
  localparam logic [15:0] BMCR_RESET = 16'h8000;
  localparam logic [15:0] BMCR_AN_RESTART = 16'h1200;
  typedef enum logic [2:0] {
    S_PWRUP, S_BMCR_RST, S_RST_POLL, S_AN_START, S_IDLE, S_POLL_BMSR, S_POLL_PHYSR, S_HOST
  } state_t;
endpackage

// File: rtl/mdio_frame_engine.sv
// mdio_frame_engine: serialises one 64-bit MDIO clause-22 frame and captures read data
module mdio_frame_engine
  import eth_mdio_pkg::*;
#(
  parameter int CLK_DIV = 25,
  parameter logic [4:0] PHY_ADDR = 5'd1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic        write,
  input  logic [4:0]  reg_addr,
  input  logic [15:0] wdata,
  output logic        busy,
  output logic        done,
  output logic [15:0] rdata,
  output logic        mdc,
  output logic        mdio_o,
  output logic        mdio_t,
  input  logic        mdio_i
);
  localparam int DW = $clog2(CLK_DIV + 1);
  localparam logic [DW-1:0] DIV_MAX = DW'(CLK_DIV - 1);
  logic [DW-1:0] div;
  logic [5:0] bit_idx, nxt;
  logic [62:0] sh;
  logic [63:0] frame;
  logic wr_q, tick;
  assign frame = {32'hFFFF_FFFF, 2'b01, write ? OP_WR : OP_RD, PHY_ADDR, reg_addr,
                  write ? 2'b10 : 2'b00, write ? wdata : 16'h0000};
  assign tick = div == DIV_MAX;
  assign nxt = bit_idx + 6'd1;
  // rising MDC edges shift mdio_i in; after the last one rdata holds the 16 data bits
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      busy <= 1'b0;
      done <= 1'b0;
      mdc <= 1'b0;
      mdio_o <= 1'b0;
      mdio_t <= 1'b1;
      div <= '0;
      bit_idx <= '0;
      sh <= '0;
      wr_q <= 1'b0;
      rdata <= '0;
    end else begin
      done <= 1'b0;
      if (!busy) begin
        if (start) begin
          busy <= 1'b1;
          wr_q <= write;
          sh <= frame[62:0];
          mdio_o <= frame[63];
          mdio_t <= 1'b0;
          div <= '0;
          bit_idx <= '0;
        end
      end else if (!tick) div <= div + 1'b1;
      else begin
        div <= '0;
        mdc <= !mdc;
        if (!mdc) rdata <= {rdata[14:0], mdio_i};
        else if (bit_idx == 6'd63) begin
          busy <= 1'b0;
          done <= 1'b1;
          mdio_o <= 1'b0;
          mdio_t <= 1'b1;
        end else begin
          bit_idx <= nxt;
          sh <= {sh[61:0], 1'b0};
          mdio_o <= sh[62];
          mdio_t <= !wr_q && nxt >= 6'd46;
        end
      end
    end
endmodule

// File: rtl/ethernet_mdio_ctrl.sv
// ethernet_mdio_ctrl: PHY init, periodic link polling and host register access over MDIO
module ethernet_mdio_ctrl
  import eth_mdio_pkg::*;
#(
  parameter int CLK_DIV = 25,
  parameter logic [4:0] PHY_ADDR = 5'd1,
  parameter int POWERUP_CYCLES = 1_250_000,
  parameter int POLL_CYCLES = 12_500_000,
  parameter int RST_POLL_MAX = 16,
  parameter logic [4:0] SPEED_REG = 5'd17
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic [4:0]  cmd_reg,
  input  logic [15:0] cmd_wdata,
  output logic        rsp_valid,
  output logic [15:0] rsp_rdata,
  output logic        init_done,
  output logic        init_error,
  output logic        link_up,
  output logic [1:0]  link_speed,
  output logic        mdc,
  input  logic        mdio_i,
  output logic        mdio_o,
  output logic        mdio_t
);
  localparam int PW = $clog2(POWERUP_CYCLES);
  localparam int TW = $clog2(POLL_CYCLES);
  localparam int RW = $clog2(RST_POLL_MAX);
  state_t state, state_nx;
  logic issued, start, eng_busy, eng_done, eng_write;
  logic [4:0] eng_reg, h_reg;
  logic [15:0] eng_wdata, eng_rdata, h_wdata;
  logic [PW-1:0] pwr_cnt;
  logic [TW-1:0] poll_cnt;
  logic [RW-1:0] rst_cnt;
  logic poll_pending, bmsr_link, h_write, accept, poll_go, pwr_end, poll_exp, rst_exhausted, lk, give_up;
  assign start = !(state inside {S_PWRUP, S_IDLE}) && !issued && !eng_busy;
  assign cmd_ready = state == S_IDLE && init_done;
  assign accept = cmd_valid && cmd_ready;
  assign poll_go = cmd_ready && poll_pending && !cmd_valid;
  assign pwr_end = pwr_cnt == PW'(POWERUP_CYCLES - 1);
  assign poll_exp = init_done && poll_cnt == TW'(POLL_CYCLES - 1);
  assign rst_exhausted = rst_cnt == RW'(RST_POLL_MAX - 1);
  assign give_up = state == S_RST_POLL && eng_done && eng_rdata[15] && rst_exhausted;
  assign lk = eng_rdata[10] & bmsr_link;
  mdio_frame_engine #(.CLK_DIV(CLK_DIV), .PHY_ADDR(PHY_ADDR)) u_engine (
    .clock(clock), .reset(reset), .start(start), .write(eng_write), .reg_addr(eng_reg),
    .wdata(eng_wdata), .busy(eng_busy), .done(eng_done), .rdata(eng_rdata),
    .mdc(mdc), .mdio_o(mdio_o), .mdio_t(mdio_t), .mdio_i(mdio_i)
  );
  always_ff @(posedge clock or posedge reset)
    if (reset) state <= S_PWRUP;
    else state <= state_nx;
  always_comb begin
    state_nx = state;
    eng_write = 1'b0;
    eng_reg = h_reg;
    eng_wdata = h_wdata;
    case (state)
      S_PWRUP: state_nx = pwr_end ? S_BMCR_RST : S_PWRUP;
      S_BMCR_RST: begin
        eng_write = 1'b1;
        eng_reg = REG_BMCR;
        eng_wdata = BMCR_RESET;
        state_nx = eng_done ? S_RST_POLL : state;
      end
      S_RST_POLL: begin
        eng_reg = REG_BMCR;
        state_nx = !eng_done ? state : !eng_rdata[15] ? S_AN_START : rst_exhausted ? S_IDLE : state;
      end
      S_AN_START: begin
        eng_write = 1'b1;
        eng_reg = REG_BMCR;
        eng_wdata = BMCR_AN_RESTART;
        state_nx = eng_done ? S_IDLE : state;
      end
      S_IDLE: state_nx = accept ? S_HOST : poll_go ? S_POLL_BMSR : S_IDLE;
      S_POLL_BMSR: begin
        eng_reg = REG_BMSR;
        state_nx = eng_done ? S_POLL_PHYSR : state;
      end
      S_POLL_PHYSR: begin
        eng_reg = SPEED_REG;
        state_nx = eng_done ? S_IDLE : state;
      end
      S_HOST: begin
        eng_write = h_write;
        state_nx = eng_done ? S_IDLE : state;
      end
      default: state_nx = S_PWRUP;
    endcase
  end
  // the poll timer reloads at terminal count; a pending poll waits for an idle slot
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      issued <= 1'b0;
      pwr_cnt <= '0;
      poll_cnt <= '0;
      rst_cnt <= '0;
      poll_pending <= 1'b0;
      bmsr_link <= 1'b0;
      h_write <= 1'b0;
      h_reg <= '0;
      h_wdata <= '0;
      init_done <= 1'b0;
      init_error <= 1'b0;
      link_up <= 1'b0;
      link_speed <= 2'b00;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
    end else begin
      issued <= start ? 1'b1 : eng_done ? 1'b0 : issued;
      pwr_cnt <= state == S_PWRUP && !pwr_end ? pwr_cnt + 1'b1 : pwr_cnt;
      rst_cnt <= state == S_RST_POLL && eng_done && !rst_exhausted ? rst_cnt + 1'b1 : rst_cnt;
      init_done <= init_done || give_up || (state == S_AN_START && eng_done);
      init_error <= init_error || give_up;
      poll_cnt <= !init_done ? poll_cnt : poll_exp ? '0 : poll_cnt + 1'b1;
      poll_pending <= poll_exp || (poll_pending && !poll_go);
      if (accept) {h_write, h_reg, h_wdata} <= {cmd_write, cmd_reg, cmd_wdata};
      if (state == S_POLL_BMSR && eng_done) bmsr_link <= eng_rdata[5];
      if (state == S_POLL_PHYSR && eng_done) begin
        link_up <= lk;
        link_speed <= lk ? eng_rdata[15:14] : 2'b00;
      end
      rsp_valid <= state == S_HOST && eng_done;
      if (state == S_HOST && eng_done) rsp_rdata <= h_write ? 16'h0000 : eng_rdata;
    end
endmodule
